// File: rtl/fifo_math_pkg.sv
// Shared definitions for the multi-channel FIFO with a math datapath on pop:
// operation encodings and width helpers used by the top and the channel.
package fifo_math_pkg;

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_SUM  = 2'd1,
    OP_MAX  = 2'd2,
    OP_SQR  = 2'd3
  } op_e;

  // Result is wide enough to hold the exact square of a data word.
  function automatic int res_w(input int data_w);
    return 2 * data_w;
  endfunction

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Channel select is at least one bit even for a single channel.
  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/fifo_math_chan.sv
// One FIFO channel: storage, read/write pointers, occupancy and flags.
// The wr/rd inputs are already qualified by channel select; this block
// decides acceptance and reports it back so the top can track errors.
module fifo_math_chan
  import fifo_math_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  localparam int CNT_W = cnt_w(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_ok,
  output logic              rd_ok,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;

  // Flags come straight from the registered occupancy.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A read never uses a word written in the same cycle; a write into a
  // full channel only goes through when a read frees a slot that cycle.
  assign rd_ok   = rd & ~empty;
  assign wr_ok   = wr & (~full | rd_ok);
  assign rd_data = mem[rptr];

  // Storage array: data only, no reset; stale words are unreachable once
  // the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= datain;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  // Occupancy tracks net pushes minus pops; simultaneous push/pop holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_math_param.sv
// Multi-channel FIFO whose pops feed a small math unit. Each accepted read
// registers the popped word and an operation result computed against the
// previous result when the operation is repeated, or against zero when the
// operation changes. Overflow and underflow are sticky until cleared.
module fifo_math_param
  import fifo_math_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int DEPTH   = 8,
  parameter int NUM_CH  = 2,
  localparam int CH_W   = ch_w(NUM_CH),
  localparam int RES_W  = res_w(DATA_W),
  localparam int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] datain,
  input  logic              wr,
  input  logic              rd,
  input  logic [CH_W-1:0]   sel,
  input  logic [1:0]        math,
  input  logic              clr_err,
  output logic [DATA_W-1:0] dataout,
  output logic [RES_W-1:0]  result,
  output logic              result_valid,
  output logic [NUM_CH-1:0] full,
  output logic [NUM_CH-1:0] empty,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  output logic              udf
);

  logic [NUM_CH-1:0] wr_ok_vec;
  logic [NUM_CH-1:0] rd_ok_vec;
  logic [DATA_W-1:0] chan_rd_data [NUM_CH];
  logic [CNT_W-1:0]  chan_cnt     [NUM_CH];

  logic [DATA_W-1:0] pop_word;
  logic              sel_hit;
  logic              rd_hit;
  logic              wr_rej;
  logic              rd_rej;
  op_e               op;
  op_e               last_op;
  logic [RES_W-1:0]  prior;
  logic              vld_p1;

  // Apply one operation to a popped word; all math is unsigned.
  function automatic logic [RES_W-1:0] apply_op(input op_e            f_op,
                                                input logic [RES_W-1:0]  f_prior,
                                                input logic [DATA_W-1:0] f_word);
    logic [RES_W-1:0] ext;
    ext = {{(RES_W-DATA_W){1'b0}}, f_word};
    case (f_op)
      OP_PASS: return ext;
      OP_SUM:  return f_prior + ext;
      OP_MAX:  return (ext > f_prior) ? ext : f_prior;
      OP_SQR:  return ext * ext;
      default: return ext;
    endcase
  endfunction

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_chan
      fifo_math_chan #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_chan (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (wr & (sel == CH_W'(g))),
        .rd      (rd & (sel == CH_W'(g))),
        .datain  (datain),
        .rd_data (chan_rd_data[g]),
        .wr_ok   (wr_ok_vec[g]),
        .rd_ok   (rd_ok_vec[g]),
        .count   (chan_cnt[g]),
        .full    (full[g]),
        .empty   (empty[g])
      );
    end
  endgenerate

  // Route the selected channel's occupancy and head word; an out-of-range
  // select (non power-of-two NUM_CH) reads as an empty, idle channel.
  always_comb begin
    count    = '0;
    pop_word = '0;
    sel_hit  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == CH_W'(i)) begin
        sel_hit  = 1'b1;
        count    = chan_cnt[i];
        pop_word = chan_rd_data[i];
      end
    end
  end

  assign rd_hit = |rd_ok_vec;
  assign wr_rej = wr & sel_hit & ~(|wr_ok_vec);
  assign rd_rej = rd & sel_hit & ~rd_hit;
  assign op     = op_e'(math);

  // Accumulating ops restart from zero whenever the operation changes.
  assign prior = (op == last_op) ? result : '0;

  // Pop stage: capture word and result on an accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataout <= '0;
      result  <= '0;
      last_op <= OP_PASS;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= rd_hit;
      if (rd_hit) begin
        dataout <= pop_word;
        result  <= apply_op(op, prior, pop_word);
        last_op <= op;
      end
    end
  end

  assign result_valid = vld_p1;

  // Sticky error flags; a new error in the same cycle beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= wr_rej | (ovf & ~clr_err);
      udf <= rd_rej | (udf & ~clr_err);
    end
  end

endmodule

// File: tb/tb_fifo_math_param.sv
// Directed bench for fifo_math_param with default parameters.
module tb_fifo_math_param;

  logic       clk;
  logic       rst_n;
  logic [3:0] datain;
  logic       wr;
  logic       rd;
  logic [0:0] sel;
  logic [1:0] math;
  logic       clr_err;
  logic [3:0] dataout;
  logic [7:0] result;
  logic       result_valid;
  logic [1:0] full;
  logic [1:0] empty;
  logic [3:0] count;
  logic       ovf;
  logic       udf;

  int total;
  int bad;

  fifo_math_param dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .datain       (datain),
    .wr           (wr),
    .rd           (rd),
    .sel          (sel),
    .math         (math),
    .clr_err      (clr_err),
    .dataout      (dataout),
    .result       (result),
    .result_valid (result_valid),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .ovf          (ovf),
    .udf          (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given controls; outputs sampled 1ns after the edge.
  task automatic cycle(input logic [0:0] ch, input logic w, input logic r,
                       input logic [3:0] d, input logic [1:0] m, input logic c);
    sel     = ch;
    wr      = w;
    rd      = r;
    datain  = d;
    math    = m;
    clr_err = c;
    @(posedge clk);
    #1;
    wr      = 1'b0;
    rd      = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic push(input logic [0:0] ch, input logic [3:0] d);
    cycle(ch, 1'b1, 1'b0, d, 2'd0, 1'b0);
  endtask

  task automatic pop_chk(input string tag, input logic [0:0] ch, input logic [1:0] m,
                         input int exp_d, input int exp_r);
    cycle(ch, 1'b0, 1'b1, 4'd0, m, 1'b0);
    chk({tag, ".dout"}, 32'(dataout), exp_d);
    chk({tag, ".res"}, 32'(result), exp_r);
    chk({tag, ".vld"}, 32'(result_valid), 1);
  endtask

  int v38_d[4] = '{8, 4, 14, 5};
  int v39_d[4] = '{11, 1, 10, 12};
  int v39_r[4] = '{'h0B, 'h0C, 'h16, 'h22};
  int v40_d[4] = '{2, 14, 15, 4};
  int v40_r[4] = '{2, 14, 15, 15};

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    datain  = '0;
    wr      = 1'b0;
    rd      = 1'b0;
    sel     = '0;
    math    = '0;
    clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.empty", 32'(empty), 3);
    chk("rst.full", 32'(full), 0);
    chk("rst.count", 32'(count), 0);
    chk("rst.dout", 32'(dataout), 0);
    chk("rst.res", 32'(result), 0);
    chk("rst.vld", 32'(result_valid), 0);
    chk("rst.ovf", 32'(ovf), 0);
    chk("rst.udf", 32'(udf), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pass-through on channel 0
    for (int i = 0; i < 4; i++) push(1'b0, 4'(v38_d[i]));
    chk("pass.count", 32'(count), 4);
    for (int i = 0; i < 4; i++) pop_chk($sformatf("pass%0d", i), 1'b0, 2'd0, v38_d[i], v38_d[i]);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
    chk("pass.vld_drop", 32'(result_valid), 0);
    chk("pass.empty0", 32'(empty[0]), 1);

    // Running sum on channel 1; channel 0 must stay idle
    for (int i = 0; i < 4; i++) push(1'b1, 4'(v39_d[i]));
    chk("sum.empty", 32'(empty), 1);
    sel = 1'b0;
    #1;
    chk("sum.ch0_count", 32'(count), 0);
    sel = 1'b1;
    #1;
    chk("sum.ch1_count", 32'(count), 4);
    for (int i = 0; i < 4; i++) pop_chk($sformatf("sum%0d", i), 1'b1, 2'd1, v39_d[i], v39_r[i]);
    chk("sum.empty_end", 32'(empty), 3);

    // Running max, then squares
    for (int i = 0; i < 4; i++) push(1'b0, 4'(v40_d[i]));
    for (int i = 0; i < 4; i++) pop_chk($sformatf("max%0d", i), 1'b0, 2'd2, v40_d[i], v40_r[i]);
    push(1'b0, 4'd10);
    push(1'b0, 4'd15);
    pop_chk("sqr0", 1'b0, 2'd3, 10, 'h64);
    pop_chk("sqr1", 1'b0, 2'd3, 15, 'hE1);

    // Overflow: 9 writes into an 8-deep channel
    for (int i = 0; i < 8; i++) push(1'b0, 4'(i + 1));
    chk("ovf.full_at8", 32'(full[0]), 1);
    chk("ovf.ovf_before", 32'(ovf), 0);
    push(1'b0, 4'hF);
    chk("ovf.ovf", 32'(ovf), 1);
    chk("ovf.count", 32'(count), 8);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("drain%0d", i), 1'b0, 2'd0, i + 1, i + 1);
    chk("udf.before", 32'(udf), 0);
    cycle(1'b0, 1'b0, 1'b1, 4'd0, 2'd0, 1'b0);
    chk("udf.udf", 32'(udf), 1);
    chk("udf.vld", 32'(result_valid), 0);
    chk("udf.dout_hold", 32'(dataout), 8);
    chk("udf.res_hold", 32'(result), 8);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1);
    chk("clr.ovf", 32'(ovf), 0);
    chk("clr.udf", 32'(udf), 0);

    // Write+read on an empty channel: write lands, read is an underflow that beats clear
    cycle(1'b0, 1'b1, 1'b1, 4'd5, 2'd0, 1'b1);
    chk("wrrd_empty.count", 32'(count), 1);
    chk("wrrd_empty.udf", 32'(udf), 1);
    chk("wrrd_empty.vld", 32'(result_valid), 0);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1);
    chk("wrrd_empty.clr", 32'(udf), 0);
    pop_chk("wrrd_empty.pop", 1'b0, 2'd0, 5, 5);

    // Full channel with simultaneous read and write across pointer wrap
    for (int i = 0; i < 8; i++) push(1'b0, 4'(i + 1));
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 4'(i + 9), 2'd0, 1'b0);
      chk($sformatf("fullrw%0d.dout", i), 32'(dataout), i + 1);
      chk($sformatf("fullrw%0d.count", i), 32'(count), 8);
    end
    chk("fullrw.ovf", 32'(ovf), 0);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("wrap%0d", i), 1'b0, 2'd0, i + 5, i + 5);

    // Asynchronous reset with data held
    push(1'b0, 4'd3);
    push(1'b0, 4'd6);
    push(1'b0, 4'd9);
    push(1'b0, 4'd12);
    pop_chk("prerst", 1'b0, 2'd1, 3, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.empty", 32'(empty), 3);
    chk("arst.count", 32'(count), 0);
    chk("arst.res", 32'(result), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(1'b0, 4'd7);
    pop_chk("postrst", 1'b0, 2'd1, 7, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
